fw_scan_chain_seq: RTL

Parametrised scan-chain test sequencer for the IP2 pixel firmware, generalising the single-chain TEST2/TEST4 flows to N parallel chains with a buffered word interface. It steps a fixed state sequence (delay, reset_not, scan_load pulse, serial shift) on bxclk-period ticks. It drives the ASIC scan pins and captures the returned chain into a readable buffer. It sits between the AXI register decoder (OP_CODE_W_EXECUTE, R_DATA_ARRAY) and the ASIC pad logic.

---
 rtl/fw_scan_chain_seq_if.sv | 48 ++++
 rtl/fw_scan_chain_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fw_scan_chain_seq_if.sv
// Port bundle for fw_scan_chain_seq: tick/launch control, latched test configuration,
// tx/rx buffer word ports and the ASIC scan pins.
interface fw_scan_chain_seq_if #(
   parameter int SCAN_BITS = 768,
   parameter int CHAINS    = 1,
   parameter int DELAY_W   = 6,
   parameter int TRIG_W    = 6
);
   localparam int WORDS = SCAN_BITS / 32;
   localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

   logic               bx_tick;
   logic               start;
   logic               abort;
   logic [DELAY_W-1:0] test_delay;
   logic [DELAY_W-1:0] scanload_delay;
   logic               scanload_delay_disable;
   logic [TRIG_W-1:0]  trig_pos;
   logic               mask_reset_not;
   logic               mode_shift;
   logic               loopback;
   logic               tx_wr_en;
   logic [AW-1:0]      tx_wr_addr;
   logic [31:0]        tx_wr_data;
   logic [AW-1:0]      rx_rd_addr;
   logic [31:0]        rx_rd_data;
   logic [CHAINS-1:0]  scan_out;
   logic [CHAINS-1:0]  scan_in;
   logic               scan_load;
   logic               reset_not;
   logic               vin_test_trig_out;
   logic               busy;
   logic               done;

   modport master (
      output bx_tick, start, abort, test_delay, scanload_delay, scanload_delay_disable,
             trig_pos, mask_reset_not, mode_shift, loopback, tx_wr_en, tx_wr_addr,
             tx_wr_data, rx_rd_addr, scan_out,
      input  rx_rd_data, scan_in, scan_load, reset_not, vin_test_trig_out, busy, done
   );

   modport slave (
      input  bx_tick, start, abort, test_delay, scanload_delay, scanload_delay_disable,
             trig_pos, mask_reset_not, mode_shift, loopback, tx_wr_en, tx_wr_addr,
             tx_wr_data, rx_rd_addr, scan_out,
      output rx_rd_data, scan_in, scan_load, reset_not, vin_test_trig_out, busy, done
   );
endinterface

// File: rtl/fw_scan_chain_seq.sv
// Scan-chain test sequencer: delay / reset_not / scan_load pulse / N-chain serial shift on bx ticks.
// Define CMS_PIX28_SCAN_LOOPBACK_EN to let the loopback input capture scan_in instead of scan_out.
module fw_scan_chain_seq #(
   parameter int SCAN_BITS = 768,
   parameter int CHAINS    = 1,
   parameter int DELAY_W   = 6,
   parameter int TRIG_W    = 6
) (
   input logic                fw_pl_clk1,
   input logic                fw_rst_n,
   fw_scan_chain_seq_if.slave bus
);
   localparam int WORDS = SCAN_BITS / 32;
   localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int L     = SCAN_BITS / CHAINS;
   localparam int WPC   = L / 32;
   localparam int SH_W  = $clog2(L) + 1;
   localparam int CNT_W = (DELAY_W > SH_W) ? DELAY_W : SH_W;
   localparam int TC_W  = TRIG_W + 1;

   typedef enum logic [2:0] {
      IDLE, DELAY_TEST, RESET_NOT, DELAY_SCANLOAD, SCANLOAD_1, SCANLOAD_2, SHIFT, DONE
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
   logic [TC_W-1:0]    trig_cnt_q, trig_cnt_d;

   logic [DELAY_W-1:0] test_delay_q, scanload_delay_q;
   logic [TRIG_W-1:0]  trig_pos_q;
   logic               sl_dis_q, mask_rn_q, mode_shift_q;

   logic               scan_load_q, scan_load_d;
   logic               reset_not_q, reset_not_d;
   logic               trig_q, trig_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [CHAINS-1:0]  scan_in_q, scan_in_d;
   logic [31:0]        rx_rd_data_q;

   logic [31:0]        tx_mem [WORDS];
   logic [31:0]        rx_mem [WORDS];

   logic               launch, tick;
   logic [CHAINS-1:0]  cap;

   assign tick    = bus.bx_tick;
   assign launch  = (state_q == IDLE) && bus.start && !bus.abort;
   assign cnt_inc = cnt_q + CNT_W'(1);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      trig_cnt_d = trig_cnt_q;
      if (tick && (trig_cnt_q != '1)) trig_cnt_d = trig_cnt_q + TC_W'(1);

      unique case (state_q)
         IDLE: begin
            if (launch) begin
               state_d    = DELAY_TEST;
               cnt_d      = '0;
               // Parked at all-ones so no trig_pos value can match before RESET_NOT ends.
               trig_cnt_d = '1;
            end
         end
         DELAY_TEST: begin
            if (tick) begin
               if (cnt_inc >= CNT_W'(test_delay_q)) state_d = RESET_NOT;
               else                                 cnt_d   = cnt_inc;
            end
         end
         RESET_NOT: begin
            if (tick) begin
               trig_cnt_d = '0;
               cnt_d      = '0;
               state_d    = (!sl_dis_q && (scanload_delay_q != '0)) ? DELAY_SCANLOAD : SCANLOAD_1;
            end
         end
         DELAY_SCANLOAD: begin
            if (tick) begin
               if (cnt_inc >= CNT_W'(scanload_delay_q)) state_d = SCANLOAD_1;
               else                                     cnt_d   = cnt_inc;
            end
         end
         SCANLOAD_1: begin
            if (tick) state_d = SCANLOAD_2;
         end
         SCANLOAD_2: begin
            if (tick) begin
               cnt_d   = '0;
               state_d = mode_shift_q ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            if (tick) begin
               if (cnt_q == CNT_W'(L - 1)) state_d = DONE;
               else                        cnt_d   = cnt_inc;
            end
         end
         DONE: begin
            if (tick) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (bus.abort) state_d = IDLE;

      // Outputs are decoded from the next state so they land on the same edge as the transition.
      scan_load_d = !((state_d == DELAY_SCANLOAD) || (state_d == SHIFT));
      reset_not_d = !((state_d == RESET_NOT) && !mask_rn_q);
      busy_d      = (state_d != IDLE);
      trig_d      = (state_d != IDLE) && (state_d != DONE) && (trig_cnt_d == TC_W'(trig_pos_q));
      scan_in_d   = '0;
      if (state_d == SHIFT) begin
         for (int c = 0; c < CHAINS; c++) begin
            scan_in_d[c] = tx_mem[AW'(c * WPC + int'(cnt_d >> 5))][cnt_d[4:0]];
         end
      end

      done_d = done_q;
      if (launch)                                          done_d = 1'b0;
      else if ((state_q == DONE) && tick && !bus.abort)    done_d = 1'b1;
   end

   always_ff @(posedge fw_pl_clk1 or negedge fw_rst_n) begin
      if (!fw_rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         trig_cnt_q  <= '1;
         scan_load_q <= 1'b1;
         reset_not_q <= 1'b1;
         scan_in_q   <= '0;
         trig_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         trig_cnt_q  <= trig_cnt_d;
         scan_load_q <= scan_load_d;
         reset_not_q <= reset_not_d;
         scan_in_q   <= scan_in_d;
         trig_q      <= trig_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   always_ff @(posedge fw_pl_clk1 or negedge fw_rst_n) begin
      if (!fw_rst_n) begin
         test_delay_q     <= '0;
         scanload_delay_q <= '0;
         trig_pos_q       <= '0;
         sl_dis_q         <= 1'b0;
         mask_rn_q        <= 1'b0;
         mode_shift_q     <= 1'b0;
      end else if (launch) begin
         test_delay_q     <= bus.test_delay;
         scanload_delay_q <= bus.scanload_delay;
         trig_pos_q       <= bus.trig_pos;
         sl_dis_q         <= bus.scanload_delay_disable;
         mask_rn_q        <= bus.mask_reset_not;
         mode_shift_q     <= bus.mode_shift;
      end
   end

`ifdef CMS_PIX28_SCAN_LOOPBACK_EN
   logic loopback_q;

   always_ff @(posedge fw_pl_clk1 or negedge fw_rst_n) begin
      if (!fw_rst_n)   loopback_q <= 1'b0;
      else if (launch) loopback_q <= bus.loopback;
   end

   assign cap = loopback_q ? scan_in_q : bus.scan_out;
`else
   logic unused_loopback;

   assign unused_loopback = bus.loopback;
   assign cap             = bus.scan_out;
`endif

   // Buffers hold their contents across reset and abort.
   always_ff @(posedge fw_pl_clk1) begin
      if (bus.tx_wr_en && (state_q == IDLE) && (int'(bus.tx_wr_addr) < WORDS)) begin
         tx_mem[bus.tx_wr_addr] <= bus.tx_wr_data;
      end
      if ((state_q == SHIFT) && tick) begin
         for (int c = 0; c < CHAINS; c++) begin
            rx_mem[AW'(c * WPC + int'(cnt_q >> 5))][cnt_q[4:0]] <= cap[c];
         end
      end
   end

   always_ff @(posedge fw_pl_clk1 or negedge fw_rst_n) begin
      if (!fw_rst_n) rx_rd_data_q <= '0;
      else           rx_rd_data_q <= (int'(bus.rx_rd_addr) < WORDS) ? rx_mem[bus.rx_rd_addr] : '0;
   end

   assign bus.rx_rd_data        = rx_rd_data_q;
   assign bus.scan_in           = scan_in_q;
   assign bus.scan_load         = scan_load_q;
   assign bus.reset_not         = reset_not_q;
   assign bus.vin_test_trig_out = trig_q;
   assign bus.busy              = busy_q;
   assign bus.done              = done_q;
endmodule
